// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with HI/LO result registers.
// MUL/MULU take 5 busy cycles, DIV/DIVU take 10. Operands are latched on the
// accept edge and the result is written on the edge that ends the busy period.
// Optional feature macro: MDU_DIVZERO_KEEP_EN. When defined, a divide by zero
// is absorbed on the accept edge with no busy period and HI/LO stay unchanged.
// When undefined, a divide by zero runs the full 10-cycle busy period and then
// writes HI=A, LO=0xFFFFFFFF.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        move_to,
    input  logic [2:0]  sel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] rd_data
);

    localparam logic [2:0] SEL_MUL  = 3'd1;
    localparam logic [2:0] SEL_MULU = 3'd2;
    localparam logic [2:0] SEL_DIV  = 3'd3;
    localparam logic [2:0] SEL_DIVU = 3'd4;
    localparam logic [2:0] SEL_HI   = 3'd5;
    localparam logic [2:0] SEL_LO   = 3'd6;

    localparam logic [3:0] LAT_MUL  = 4'd5;
    localparam logic [3:0] LAT_DIV  = 4'd10;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_op;
    logic        w_is_div;
    logic        w_accept;
    logic        w_divzero_skip;
    logic        w_move;
    logic [63:0] w_result;

    // 64-bit product; signed mode sign-extends both operands first
    function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        [63:0] ua;
        logic        [63:0] ub;
        sa = signed'({{32{a[31]}}, a});
        sb = signed'({{32{b[31]}}, b});
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (sgn)
            return 64'(sa * sb);
        else
            return ua * ub;
    endfunction

    // Returns {HI=remainder, LO=quotient}; zero divisor and the single signed
    // overflow case are resolved explicitly rather than left to the operator
    function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        sa = signed'(a);
        sb = signed'(b);
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'd0, 32'h8000_0000};
        else if (sgn) begin
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end else
            return {a % b, a / b};
    endfunction

    assign w_is_op  = (sel >= SEL_MUL) && (sel <= SEL_DIVU);
    assign w_is_div = (sel == SEL_DIV) || (sel == SEL_DIVU);
    assign w_accept = start && (r_state == ST_IDLE) && w_is_op;
`ifdef MDU_DIVZERO_KEEP_EN
    assign w_divzero_skip = w_is_div && (rt_val == 32'd0);
`else
    assign w_divzero_skip = 1'b0;
`endif
    assign w_move   = move_to && (r_state == ST_IDLE) && !w_accept &&
                      ((sel == SEL_HI) || (sel == SEL_LO));

    // Result computed from the latched operands, consumed on the final busy edge
    always_comb begin
        w_result = 64'd0;
        case (r_op)
            SEL_MUL:  w_result = f_mul(r_a, r_b, 1'b1);
            SEL_MULU: w_result = f_mul(r_a, r_b, 1'b0);
            SEL_DIV:  w_result = f_div(r_a, r_b, 1'b1);
            SEL_DIVU: w_result = f_div(r_a, r_b, 1'b0);
            default:  w_result = 64'd0;
        endcase
    end

    // IDLE/RUN sequencer with down-counter; owns operand latches and HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_divzero_skip) begin
                        r_state <= ST_RUN;
                        r_cnt   <= w_is_div ? LAT_DIV : LAT_MUL;
                        r_op    <= sel;
                        r_a     <= rs_val;
                        r_b     <= rt_val;
                    end else if (w_move) begin
                        if (sel == SEL_HI)
                            r_hi <= rs_val;
                        else
                            r_lo <= rs_val;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                        r_hi    <= w_result[63:32];
                        r_lo    <= w_result[31:0];
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);

    // Read port mux straight from HI/LO; holds old values while busy
    always_comb begin
        rd_data = 32'd0;
        if (sel == SEL_HI)
            rd_data = r_hi;
        else if (sel == SEL_LO)
            rd_data = r_lo;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: vector table plus hand sequences for
// moves, ignored starts, mid-operation reset and start right after reset.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        move_to;
    logic [2:0]  sel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] rd_data;

    int total = 0;
    int bad   = 0;

    mul_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .move_to (move_to),
        .sel     (sel),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        sel = 3'd5;
        #1 hi = rd_data;
        sel = 3'd6;
        #1 lo = rd_data;
        sel = 3'd0;
    endtask

    // Launch one operation, scramble operands afterwards, count busy cycles
    task automatic run_op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        start  = 1'b1;
        sel    = s;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        sel    = 3'd0;
        rs_val = $urandom;
        rt_val = $urandom;
        cycles = 0;
        while (busy && cycles < 30) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          stray;

        reset   = 1'b1;
        start   = 1'b0;
        move_to = 1'b0;
        sel     = 3'd0;
        rs_val  = 32'd0;
        rt_val  = 32'd0;

        vecs[0] = '{"mul_neg",     3'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{"mulu_big",    3'd2, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{"div_m7_2",    3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"div_ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{"div_7_m2",    3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[5] = '{"divu_100_7",  3'd4, 32'd100,       32'd7,        10, 32'h0000_0002, 32'h0000_000E};
        vecs[6] = '{"mul_max",     3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,  32'h3FFF_FFFF, 32'h0000_0001};
        vecs[7] = '{"mulu_max",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
`ifdef MDU_DIVZERO_KEEP_EN
        vecs[8] = '{"divu_by0",    3'd4, 32'd5,         32'd0,        0,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[9] = '{"div_by0",     3'd3, 32'hFFFF_FFF8, 32'd0,        0,  32'hFFFF_FFFE, 32'h0000_0001};
`else
        vecs[8] = '{"divu_by0",    3'd4, 32'd5,         32'd0,        10, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[9] = '{"div_by0",     3'd3, 32'hFFFF_FFF8, 32'd0,        10, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Moves into HI and LO
        @(negedge clk);
        move_to = 1'b1; sel = 3'd5; rs_val = 32'h1234;
        @(negedge clk);
        move_to = 1'b0;
        read_hilo(hi, lo);
        chk("move_hi", hi, 32'h1234);
        chk("move_lo_untouched", lo, 32'd0);
        @(negedge clk);
        move_to = 1'b1; sel = 3'd6; rs_val = 32'hABCD;
        @(negedge clk);
        move_to = 1'b0;
        read_hilo(hi, lo);
        chk("move_lo", lo, 32'hABCD);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            chk({vecs[i].nm, "_busy"}, 32'(cyc), 32'(vecs[i].cyc));
            read_hilo(hi, lo);
            chk({vecs[i].nm, "_hi"}, hi, vecs[i].hi);
            chk({vecs[i].nm, "_lo"}, lo, vecs[i].lo);
        end

        // Start and move issued while busy are ignored
        @(negedge clk);
        start = 1'b1; sel = 3'd2; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0; sel = 3'd0;
        cyc = 0;
        while (busy && cyc < 30) begin
            cyc++;
            if (cyc == 2) begin
                start = 1'b1; sel = 3'd3; rs_val = 32'd100; rt_val = 32'd0;
            end else if (cyc == 3) begin
                start = 1'b0; move_to = 1'b1; sel = 3'd5; rs_val = 32'hDEAD;
            end else begin
                start = 1'b0; move_to = 1'b0; sel = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; move_to = 1'b0; sel = 3'd0;
        chk("ign_busy", 32'(cyc), 32'd5);
        read_hilo(hi, lo);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd12);
        @(negedge clk);
        chk("ign_idle", {31'd0, busy}, 32'd0);

        // Reset in busy cycle 3 of a DIVU
        @(negedge clk);
        start = 1'b1; sel = 3'd4; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; sel = 3'd0;
        chk("mid_busy1", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy) stray++;
        end
        chk("mid_no_busy", 32'(stray), 32'd0);
        read_hilo(hi, lo);
        chk("mid_late_hi", hi, 32'd0);
        chk("mid_late_lo", lo, 32'd0);

        // Start on the first edge after reset release
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1; sel = 3'd1; rs_val = 32'hFFFF_FFFD; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0; sel = 3'd0;
        cyc = 0;
        while (busy && cyc < 30) begin
            cyc++;
            @(negedge clk);
        end
        chk("post_rst_busy", 32'(cyc), 32'd5);
        read_hilo(hi, lo);
        chk("post_rst_hi", hi, 32'hFFFF_FFFF);
        chk("post_rst_lo", lo, 32'hFFFF_FFF7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
